seanetnackgenerator_ddr_bitmapcmd_rd: RTL

- Read-side counterpart of the NACK-generator bitmap DDR write path.
- Accepts a bitmap read command (DDR address and beat count) and splits it into AXI4 INCR read bursts that never cross a 4 KB boundary.
- Returns the 512-bit bitmap words to the NACK scan logic as a valid/ready stream with a command-level last flag.
- Only one command is in flight at a time; each burst is a single AXI read transaction with ID AXI_ID_SET.

---
 rtl/seanetnackgenerator_ddr_bitmapcmd_rd.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/seanetnackgenerator_ddr_bitmapcmd_rd.sv
// Bitmap DDR read-command engine for the NACK generator.
// A command (byte address + beat count) is split into AXI4 INCR read bursts
// that never cross a 4 KB page. Returned 512-bit words are passed straight
// through to the NACK scan logic with a command-level last flag.
module seanetnackgenerator_ddr_bitmapcmd_rd #(
    parameter int AXI_ID_WIDTH   = 4,
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 512,
    parameter int AXI_ID_SET     = 0
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic [31:0]               rd_cmd_addr,
    input  logic [7:0]                rd_cmd_len,
    input  logic                      rd_cmd_valid,
    output logic                      rd_cmd_ready,
    output logic [AXI_DATA_WIDTH-1:0] rd_data,
    output logic                      rd_data_last,
    output logic                      rd_data_err,
    output logic                      rd_data_valid,
    input  logic                      rd_data_ready,
    output logic [AXI_ID_WIDTH-1:0]   m_axi_arid,
    output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]                m_axi_arlen,
    output logic [2:0]                m_axi_arsize,
    output logic [1:0]                m_axi_arburst,
    output logic                      m_axi_arlock,
    output logic [3:0]                m_axi_arcache,
    output logic [2:0]                m_axi_arprot,
    output logic                      m_axi_arvalid,
    input  logic                      m_axi_arready,
    input  logic [AXI_ID_WIDTH-1:0]   m_axi_rid,
    input  logic [AXI_DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]                m_axi_rresp,
    input  logic                      m_axi_rlast,
    input  logic                      m_axi_rvalid,
    output logic                      m_axi_rready,
    output logic [31:0]               dfx_sta0,
    output logic [31:0]               dfx_sta1,
    output logic [31:0]               dfx_sta2,
    output logic [31:0]               dfx_sta3
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_AR   = 2'd1;
    localparam logic [1:0] ST_R    = 2'd2;

    logic [1:0]  state_q,     state_d;
    logic [31:0] cur_addr_q,  cur_addr_d;
    logic [8:0]  remain_q,    remain_d;
    logic [6:0]  burst_cnt_q, burst_cnt_d;
    logic        rlast_err_q, rlast_err_d;
    logic [31:0] cmd_cnt_q,   cmd_cnt_d;
    logic [31:0] beat_cnt_q,  beat_cnt_d;
    logic [15:0] err_cnt_q,   err_cnt_d;
    logic [15:0] ar_cnt_q,    ar_cnt_d;

    logic       cmd_xfer;
    logic       ar_xfer;
    logic       beat_xfer;
    logic       in_r;
    logic       beat_is_err;
    logic [6:0] page_beats;
    logic [6:0] burst_beats;

    // The rid field and the sub-beat address bits carry no information here.
    logic unused_inputs;
    assign unused_inputs = ^{m_axi_rid, rd_cmd_addr[5:0]};

    // Beats left before the next 4 KB boundary bound the burst length.
    assign page_beats  = 7'd64 - {1'b0, cur_addr_q[11:6]};
    assign burst_beats = (remain_q < {2'b00, page_beats}) ? remain_q[6:0] : page_beats;

    assign rd_cmd_ready  = (state_q == ST_IDLE);
    assign cmd_xfer      = rd_cmd_valid & rd_cmd_ready;

    assign m_axi_arid    = AXI_ID_SET[AXI_ID_WIDTH-1:0];
    assign m_axi_araddr  = {{(AXI_ADDR_WIDTH-32){1'b0}}, cur_addr_q};
    assign m_axi_arlen   = {1'b0, burst_beats - 7'd1};
    assign m_axi_arsize  = 3'b110;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arlock  = 1'b0;
    assign m_axi_arcache = 4'd0;
    assign m_axi_arprot  = 3'd0;
    assign m_axi_arvalid = (state_q == ST_AR);
    assign ar_xfer       = m_axi_arvalid & m_axi_arready;

    // Zero-latency pass-through of the R channel while a burst is open.
    assign in_r          = (state_q == ST_R);
    assign m_axi_rready  = in_r & rd_data_ready;
    assign rd_data_valid = in_r & m_axi_rvalid;
    assign rd_data       = m_axi_rdata;
    assign beat_is_err   = (m_axi_rresp != 2'b00);
    assign rd_data_err   = rd_data_valid & beat_is_err;
    assign rd_data_last  = rd_data_valid & (remain_q == 9'd1);
    assign beat_xfer     = rd_data_valid & rd_data_ready;

    assign dfx_sta0 = cmd_cnt_q;
    assign dfx_sta1 = beat_cnt_q;
    assign dfx_sta2 = {err_cnt_q, ar_cnt_q};
    assign dfx_sta3 = {state_q, rlast_err_q, 4'b0000, remain_q, cur_addr_q[31:16]};

    // Command FSM: latch command, issue page-bounded bursts, count beats home.
    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remain_d    = remain_q;
        burst_cnt_d = burst_cnt_q;
        rlast_err_d = rlast_err_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_xfer) begin
                    cur_addr_d = {rd_cmd_addr[31:6], 6'b000000};
                    remain_d   = {1'b0, rd_cmd_len} + 9'd1;
                    state_d    = ST_AR;
                end
            end
            ST_AR: begin
                if (ar_xfer) begin
                    burst_cnt_d = burst_beats;
                    state_d     = ST_R;
                end
            end
            ST_R: begin
                if (beat_xfer) begin
                    remain_d    = remain_q - 9'd1;
                    burst_cnt_d = burst_cnt_q - 7'd1;
                    cur_addr_d  = cur_addr_q + 32'd64;
                    // The FSM trusts its own beat count; rlast only feeds a flag.
                    if (m_axi_rlast != (burst_cnt_q == 7'd1)) begin
                        rlast_err_d = 1'b1;
                    end
                    if (burst_cnt_q == 7'd1) begin
                        state_d = (remain_q == 9'd1) ? ST_IDLE : ST_AR;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Status counters for debug visibility.
    always_comb begin
        cmd_cnt_d  = cmd_cnt_q;
        beat_cnt_d = beat_cnt_q;
        err_cnt_d  = err_cnt_q;
        ar_cnt_d   = ar_cnt_q;
        if (cmd_xfer) begin
            cmd_cnt_d = cmd_cnt_q + 32'd1;
        end
        if (ar_xfer) begin
            ar_cnt_d = ar_cnt_q + 16'd1;
        end
        if (beat_xfer) begin
            beat_cnt_d = beat_cnt_q + 32'd1;
            if (beat_is_err && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_d = err_cnt_q + 16'd1;
            end
        end
    end

    // State register; reset abandons any command in flight.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            cur_addr_q  <= 32'd0;
            remain_q    <= 9'd0;
            burst_cnt_q <= 7'd0;
            rlast_err_q <= 1'b0;
            cmd_cnt_q   <= 32'd0;
            beat_cnt_q  <= 32'd0;
            err_cnt_q   <= 16'd0;
            ar_cnt_q    <= 16'd0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remain_q    <= remain_d;
            burst_cnt_q <= burst_cnt_d;
            rlast_err_q <= rlast_err_d;
            cmd_cnt_q   <= cmd_cnt_d;
            beat_cnt_q  <= beat_cnt_d;
            err_cnt_q   <= err_cnt_d;
            ar_cnt_q    <= ar_cnt_d;
        end
    end

endmodule
